// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-back producers/hazard unit and the register-file
// write-back arbiter.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_add;
  logic [DW-1:0] alu_data;
  logic          ld_valid;
  logic [AW-1:0] ld_add;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          en_write;
  logic [AW-1:0] write_add;
  logic [DW-1:0] write_data;
  logic [AW-1:0] chk_add;
  logic          chk_pend;
  logic [CW-1:0] q_count;

  modport master (
    output alu_valid, alu_add, alu_data, ld_valid, ld_add, ld_data, chk_add,
    input  ld_ready, en_write, write_add, write_data, chk_pend, q_count
  );

  modport slave (
    input  alu_valid, alu_add, alu_data, ld_valid, ld_add, ld_data, chk_add,
    output ld_ready, en_write, write_add, write_data, chk_pend, q_count
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load write-backs onto the single register-file write port.
// ALU wins; displaced loads wait in an in-order queue that ALU writes can squash.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    r_q_add  [DEPTH];
  logic [DW-1:0]    r_q_data [DEPTH];
  logic [DEPTH-1:0] r_q_vld;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_en_write;
  logic [AW-1:0]    r_write_add;
  logic [DW-1:0]    r_write_data;

  logic          w_ld_ready;
  logic          w_alu_iss;
  logic          w_q_empty;
  logic          w_ld_live;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic          w_iss_en;
  logic [AW-1:0] w_iss_add;
  logic [DW-1:0] w_iss_data;
  logic          w_hit;

  assign w_ld_ready = (r_count < CW'(DEPTH));
  assign w_alu_iss  = bus.alu_valid && (bus.alu_add != {AW{1'b0}});
  assign w_q_empty  = (r_count == {CW{1'b0}});
  // A load is live only if accepted, non-zero, and not overwritten by a same-cycle ALU write.
  assign w_ld_live  = bus.ld_valid && w_ld_ready && (bus.ld_add != {AW{1'b0}})
                      && !(w_alu_iss && (bus.ld_add == bus.alu_add));
  assign w_push     = w_ld_live && !w_bypass;

  // Issue selection: ALU, then queue head, then direct load bypass.
  always_comb begin
    w_pop      = 1'b0;
    w_bypass   = 1'b0;
    w_iss_en   = 1'b0;
    w_iss_add  = bus.alu_add;
    w_iss_data = bus.alu_data;
    if (w_alu_iss) begin
      w_iss_en = 1'b1;
    end else if (!w_q_empty) begin
      w_pop      = 1'b1;
      w_iss_en   = r_q_vld[r_head];
      w_iss_add  = r_q_add[r_head];
      w_iss_data = r_q_data[r_head];
    end else if (w_ld_live) begin
      w_bypass   = 1'b1;
      w_iss_en   = 1'b1;
      w_iss_add  = bus.ld_add;
      w_iss_data = bus.ld_data;
    end else begin
      w_iss_en = 1'b0;
    end
  end

  // Hazard lookup across valid queue slots and the write currently on the port.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_q_vld[i] && (r_q_add[i] == bus.chk_add)) begin
        w_hit = 1'b1;
      end else begin
        w_hit = w_hit;
      end
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_add[i]  <= {AW{1'b0}};
        r_q_data[i] <= {DW{1'b0}};
      end
      r_q_vld <= {DEPTH{1'b0}};
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alu_iss && (r_q_add[i] == bus.alu_add)) begin
          r_q_vld[i] <= 1'b0;
        end
      end
      // Squashed slots still pop in order so later loads keep their position.
      if (w_pop) begin
        r_q_vld[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_q_vld[r_tail]  <= 1'b1;
        r_q_add[r_tail]  <= bus.ld_add;
        r_q_data[r_tail] <= bus.ld_data;
        r_tail           <= r_tail + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered register-file write port; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_write   <= 1'b0;
      r_write_add  <= {AW{1'b0}};
      r_write_data <= {DW{1'b0}};
    end else if (w_iss_en) begin
      r_en_write   <= 1'b1;
      r_write_add  <= w_iss_add;
      r_write_data <= w_iss_data;
    end else begin
      r_en_write <= 1'b0;
    end
  end

  assign bus.ld_ready   = w_ld_ready;
  assign bus.en_write   = r_en_write;
  assign bus.write_add  = r_write_add;
  assign bus.write_data = r_write_data;
  assign bus.q_count    = r_count;
  assign bus.chk_pend   = (bus.chk_add != {AW{1'b0}})
                          && (w_hit || (r_en_write && (r_write_add == bus.chk_add)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed vector table, reset/multi-cycle sequences,
// then random traffic against a queue-based reference model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst;

  regfile_wb_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();
  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        lv; logic [4:0] la; logic [31:0] ld;
    logic [4:0]  ck;
    logic        rdy; logic pend;
    logic        en; logic [4:0] wa; logic [31:0] wd; logic [2:0] cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  add;
    logic [31:0] data;
    logic        vld;
  } ent_t;

  vec_t tbl[$];
  ent_t mq[$];
  logic        m_en;
  logic [4:0]  m_add;
  logic [31:0] m_data;

  function automatic vec_t mk(input int av, input int aa, input logic [31:0] ad,
                              input int lv, input int la, input logic [31:0] ld, input int ck,
                              input int rdy, input int pend,
                              input int en, input int wa, input logic [31:0] wd, input int cnt);
    vec_t v;
    v.av = av[0]; v.aa = aa[4:0]; v.ad = ad;
    v.lv = lv[0]; v.la = la[4:0]; v.ld = ld;
    v.ck = ck[4:0]; v.rdy = rdy[0]; v.pend = pend[0];
    v.en = en[0]; v.wa = wa[4:0]; v.wd = wd; v.cnt = cnt[2:0];
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic [4:0] ck);
    bus.alu_valid = av; bus.alu_add = aa; bus.alu_data = ad;
    bus.ld_valid  = lv; bus.ld_add  = la; bus.ld_data  = ld;
    bus.chk_add   = ck;
  endtask

  task automatic apply(input vec_t v, input string nm);
    drive(v.av, v.aa, v.ad, v.lv, v.la, v.ld, v.ck);
    #1;
    check({nm, " ld_ready"}, 32'(bus.ld_ready), 32'(v.rdy));
    check({nm, " chk_pend"}, 32'(bus.chk_pend), 32'(v.pend));
    @(posedge clk);
    #1;
    check({nm, " en_write"}, 32'(bus.en_write), 32'(v.en));
    check({nm, " write_add"}, 32'(bus.write_add), 32'(v.wa));
    check({nm, " write_data"}, bus.write_data, v.wd);
    check({nm, " q_count"}, 32'(bus.q_count), 32'(v.cnt));
  endtask

  task automatic rand_step(input int k);
    logic av, lv, acc, keep, m_rdy, m_pend;
    logic [4:0] aa, la, ck;
    logic [31:0] ad, ld;
    ent_t h;
    av = ($urandom_range(0, 3) != 0);
    aa = 5'($urandom_range(0, 7));
    ad = $urandom;
    lv = 1'($urandom_range(0, 1));
    la = 5'($urandom_range(0, 7));
    ld = $urandom;
    ck = 5'($urandom_range(0, 7));
    drive(av, aa, ad, lv, la, ld, ck);
    #1;
    m_rdy  = (mq.size() < DEPTH);
    m_pend = 1'b0;
    if (ck != 5'd0) begin
      foreach (mq[i]) if (mq[i].vld && mq[i].add == ck) m_pend = 1'b1;
      if (m_en && m_add == ck) m_pend = 1'b1;
    end
    check($sformatf("rnd%0d ld_ready", k), 32'(bus.ld_ready), 32'(m_rdy));
    check($sformatf("rnd%0d chk_pend", k), 32'(bus.chk_pend), 32'(m_pend));
    acc  = lv && m_rdy;
    keep = acc && (la != 5'd0);
    if (av && aa != 5'd0) begin
      m_en = 1'b1; m_add = aa; m_data = ad;
      foreach (mq[i]) if (mq[i].add == aa) mq[i].vld = 1'b0;
      if (keep && la != aa) mq.push_back('{la, ld, 1'b1});
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      m_en = h.vld;
      if (h.vld) begin m_add = h.add; m_data = h.data; end
      if (keep) mq.push_back('{la, ld, 1'b1});
    end else if (keep) begin
      m_en = 1'b1; m_add = la; m_data = ld;
    end else begin
      m_en = 1'b0;
    end
    @(posedge clk);
    #1;
    check($sformatf("rnd%0d en_write", k), 32'(bus.en_write), 32'(m_en));
    check($sformatf("rnd%0d write_add", k), 32'(bus.write_add), 32'(m_add));
    check($sformatf("rnd%0d write_data", k), bus.write_data, m_data);
    check($sformatf("rnd%0d q_count", k), 32'(bus.q_count), 32'(mq.size()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            av aa ad            lv la ld            ck rdy pend en wa wd            cnt
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 0, 32'h0,        0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 5, 32'hA5A5A5A5, 5, 1, 0, 1, 5, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        5, 1, 1, 0, 5, 32'hA5A5A5A5, 0));
    tbl.push_back(mk(1, 3, 32'h11,       1, 7, 32'h22,       7, 1, 0, 1, 3, 32'h11,       1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        7, 1, 1, 1, 7, 32'h22,       0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        3, 1, 0, 0, 7, 32'h22,       0));
    tbl.push_back(mk(1, 1, 32'h101,      1, 10, 32'h201,     0, 1, 0, 1, 1, 32'h101,      1));
    tbl.push_back(mk(1, 2, 32'h102,      1, 11, 32'h202,    10, 1, 1, 1, 2, 32'h102,      2));
    tbl.push_back(mk(1, 3, 32'h103,      1, 12, 32'h203,     0, 1, 0, 1, 3, 32'h103,      3));
    tbl.push_back(mk(1, 4, 32'h104,      1, 13, 32'h204,    13, 1, 0, 1, 4, 32'h104,      4));
    tbl.push_back(mk(1, 6, 32'h105,      1, 14, 32'h205,    12, 0, 1, 1, 6, 32'h105,      4));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       14, 0, 0, 1, 10, 32'h201,     3));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 11, 32'h202,     2));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 12, 32'h203,     1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 13, 32'h204,     0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 0, 13, 32'h204,     0));
    tbl.push_back(mk(1, 8, 32'h301,      1, 9, 32'h1,        9, 1, 0, 1, 8, 32'h301,      1));
    tbl.push_back(mk(1, 9, 32'h2,        0, 0, 32'h0,        9, 1, 1, 1, 9, 32'h2,        1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        9, 1, 1, 0, 9, 32'h2,        0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        9, 1, 0, 0, 9, 32'h2,        0));
    tbl.push_back(mk(1, 4, 32'h401,      1, 4, 32'h402,      0, 1, 0, 1, 4, 32'h401,      0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        4, 1, 1, 0, 4, 32'h401,      0));
    tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'hDEAD,     0, 1, 0, 0, 4, 32'h401,      0));
    tbl.push_back(mk(1, 0, 32'hBEEF,     1, 0, 32'hDEAD,     0, 1, 0, 0, 4, 32'h401,      0));
    tbl.push_back(mk(1, 1, 32'h501,      1, 12, 32'h502,    12, 1, 0, 1, 1, 32'h501,      1));
    tbl.push_back(mk(1, 2, 32'h503,      0, 0, 32'h0,       12, 1, 1, 1, 2, 32'h503,      1));
    tbl.push_back(mk(1, 2, 32'h504,      0, 0, 32'h0,       13, 1, 0, 1, 2, 32'h504,      1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 1, 0, 1, 12, 32'h502,     0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       12, 1, 1, 0, 12, 32'h502,     0));

    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0);
    #2;
    check("reset en_write", 32'(bus.en_write), 32'h0);
    check("reset write_add", 32'(bus.write_add), 32'h0);
    check("reset write_data", bus.write_data, 32'h0);
    check("reset q_count", 32'(bus.q_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

    // Build three queued loads under ALU pressure, then reset mid-cycle.
    apply(mk(1, 21, 32'h601, 1, 17, 32'h701, 0, 1, 0, 1, 21, 32'h601, 1), "pre_rst0");
    apply(mk(1, 22, 32'h602, 1, 18, 32'h702, 0, 1, 0, 1, 22, 32'h602, 2), "pre_rst1");
    apply(mk(1, 23, 32'h603, 1, 19, 32'h703, 0, 1, 0, 1, 23, 32'h603, 3), "pre_rst2");
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd17);
    #2;
    rst = 1'b1;
    #1;
    check("midrst en_write", 32'(bus.en_write), 32'h0);
    check("midrst write_add", 32'(bus.write_add), 32'h0);
    check("midrst write_data", bus.write_data, 32'h0);
    check("midrst q_count", 32'(bus.q_count), 32'h0);
    check("midrst chk_pend", 32'(bus.chk_pend), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 17, 1, 0, 0, 0, 32'h0, 0), $sformatf("post_rst%0d", i));

    mq.delete();
    m_en = 1'b0; m_add = 5'd0; m_data = 32'h0;
    for (int k = 0; k < 500; k++) rand_step(k);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
